// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage: state encoding, default widths
// and the ID/EX control-word bit positions.
package pipe_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_CTRL_W = 10;
  localparam int unsigned DEF_CNT_W  = 16;

  // Occupancy of the stage: nothing held, main only, main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  // ID/EX control-word bit positions.
  localparam int unsigned CTRL_REGDST   = 0;
  localparam int unsigned CTRL_ALUSRC   = 1;
  localparam int unsigned CTRL_ALUOP_LO = 2;
  localparam int unsigned CTRL_ALUOP_HI = 4;
  localparam int unsigned CTRL_MEMTOREG = 5;
  localparam int unsigned CTRL_REGWR    = 6;
  localparam int unsigned CTRL_MEMWR    = 7;
  localparam int unsigned CTRL_EXTOP    = 8;
  localparam int unsigned CTRL_RTYPE    = 9;

  // Structured view of the default-width control word (MSB first).
  typedef struct packed {
    logic       r_type;
    logic       ext_op;
    logic       mem_wr;
    logic       reg_wr;
    logic       mem_to_reg;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
  } idex_ctrl_t;

  // All-zero control word is the bubble/NOP encoding.
  function automatic logic is_bubble(input logic [DEF_CTRL_W-1:0] ctrl);
    return ctrl == '0;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter: increments on inc_i, sticks at all-ones.
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  // Count qualifying cycles, holding once every bit is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage.sv
// Pipeline register stage with valid/ready handshake, flush and bubble count.
// Build option PIPE_STAGE_SKID_EN: adds a skid register so in_ready is a
// registered output (full throughput without an out_ready->in_ready path).
// Without it, a single register with in_ready = !out_valid || out_ready.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CTRL_W = DEF_CTRL_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_cnt
);

  pipe_state_e       state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              out_valid_q, out_valid_d;
  logic              accept, dequeue;

`ifdef PIPE_STAGE_SKID_EN
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;

  assign in_ready = in_ready_q;
`else
  assign in_ready = !out_valid_q || out_ready;
`endif

  assign accept  = in_valid && in_ready;
  assign dequeue = out_valid_q && out_ready;

  // Next-state and register-load decisions; flush overrides everything.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
`endif
    if (flush) begin
      state_d     = EMPTY;
      main_ctrl_d = '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_ctrl_d = '0;
`endif
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d     = ONE;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        ONE: begin
          if (accept && dequeue) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
`ifdef PIPE_STAGE_SKID_EN
          end else if (accept) begin
            state_d     = TWO;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
`endif
          end else if (dequeue) begin
            // Leaving the main register as a bubble keeps out_ctrl at 0.
            state_d     = EMPTY;
            main_ctrl_d = '0;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        TWO: begin
          if (dequeue) begin
            state_d     = ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = '0;
          end
        end
`endif
        default: state_d = EMPTY;
      endcase
    end
    out_valid_d = (state_d != EMPTY);
`ifdef PIPE_STAGE_SKID_EN
    in_ready_d  = (state_d != TWO);
`endif
  end

  // State and payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      out_valid_q <= 1'b0;
`ifdef PIPE_STAGE_SKID_EN
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      out_valid_q <= out_valid_d;
`ifdef PIPE_STAGE_SKID_EN
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (!out_valid_q && out_ready),
    .cnt_o (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage against a queue-based reference model.
module tb_pipe_stage;

`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct packed {
    logic [9:0]  c;
    logic [31:0] d;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [9:0]  in_ctrl, out_ctrl;
  logic [31:0] in_data, out_data;
  logic [15:0] bubble_cnt;

  // Narrow-counter instance, permanently idle with out_ready=1.
  logic        s_in_valid, s_in_ready, s_flush, s_out_valid, s_out_ready;
  logic [9:0]  s_in_ctrl, s_out_ctrl;
  logic [31:0] s_in_data, s_out_data;
  logic [3:0]  s_bubble_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  beat_t       mq[$];
  logic [31:0] m_last;
  logic [15:0] m_bub;
  logic        exp_rdy, obs_rdy;

  pipe_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .bubble_cnt(bubble_cnt)
  );

  pipe_stage #(.CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_ctrl(s_in_ctrl), .in_data(s_in_data), .flush(s_flush),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_ctrl(s_out_ctrl),
    .out_data(s_out_data), .bubble_cnt(s_bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic reset_dut();
    in_valid = 0; in_ctrl = '0; in_data = '0; out_ready = 0; flush = 0;
    rst_n = 0;
    mq.delete(); m_last = '0; m_bub = '0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // Drive one cycle of inputs and advance the model; returns at the next negedge.
  task automatic step(input logic v, input logic [9:0] c, input logic [31:0] d,
                      input logic ordy, input logic fl);
    logic  acc, deq;
    beat_t b;
    in_valid = v; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl;
    exp_rdy = SKID ? (mq.size() < 2) : ((mq.size() == 0) || ordy);
    #1;
    obs_rdy = in_ready;
    @(posedge clk);
    acc = v && exp_rdy;
    deq = (mq.size() > 0) && ordy;
    if ((mq.size() == 0) && ordy && (m_bub != 16'hFFFF)) m_bub = m_bub + 16'd1;
    if (fl) begin
      mq.delete();
    end else begin
      if (deq) void'(mq.pop_front());
      if (acc) begin
        b.c = c; b.d = d;
        mq.push_back(b);
      end
    end
    if (mq.size() > 0) m_last = mq[0].d;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_dut();
    checks += 5;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %h exp 0", out_valid); end
    if (out_ctrl !== 10'h0) begin failures++; $display("FAIL reset_out_ctrl got %h exp 0", out_ctrl); end
    if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %h exp 1", in_ready); end
    if (bubble_cnt !== 16'h0) begin failures++; $display("FAIL reset_bubble got %h exp 0", bubble_cnt); end
  endtask

  task automatic test_basic();
    reset_dut();
    step(1'b1, 10'h2A5, 32'hDEADBEEF, 1'b1, 1'b0);
    checks += 3;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got %h exp 1", out_valid); end
    if (out_ctrl !== 10'h2A5) begin failures++; $display("FAIL basic_ctrl got %h exp 2a5", out_ctrl); end
    if (out_data !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_data got %h exp deadbeef", out_data); end
  endtask

  task automatic test_bubble();
    reset_dut();
    repeat (5) step(1'b0, '0, '0, 1'b1, 1'b0);
    checks += 2;
    if (bubble_cnt !== 16'd5) begin failures++; $display("FAIL bubble5 got %0d exp 5", bubble_cnt); end
    if (s_bubble_cnt !== 4'd5) begin failures++; $display("FAIL bubble5_small got %0d exp 5", s_bubble_cnt); end
    repeat (15) step(1'b0, '0, '0, 1'b1, 1'b0);
    checks += 2;
    if (s_bubble_cnt !== 4'hF) begin failures++; $display("FAIL bubble_sat got %h exp f", s_bubble_cnt); end
    if (bubble_cnt !== 16'd20) begin failures++; $display("FAIL bubble20 got %0d exp 20", bubble_cnt); end
  endtask

  task automatic test_skid();
    reset_dut();
    step(1'b1, 10'h1, 32'h1, 1'b0, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
    step(1'b1, 10'h2, 32'h2, 1'b0, 1'b0);
    checks += 2;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL skid_rdy_full got %h exp 0", in_ready); end
    if (out_data !== 32'h1) begin failures++; $display("FAIL skid_head got %h exp 1", out_data); end
    step(1'b1, 10'h3, 32'h3, 1'b0, 1'b0);
    checks += 1;
    if (obs_rdy !== 1'b0) begin failures++; $display("FAIL skid_third_held got %h exp 0", obs_rdy); end
    step(1'b1, 10'h3, 32'h3, 1'b1, 1'b0);
    checks += 1;
    if (out_data !== 32'h2 || out_valid !== 1'b1) begin failures++; $display("FAIL skid_second got %h exp 2", out_data); end
    step(1'b1, 10'h3, 32'h3, 1'b1, 1'b0);
    checks += 1;
    if (out_data !== 32'h3 || out_ctrl !== 10'h3) begin failures++; $display("FAIL skid_third got %h exp 3", out_data); end
    step(1'b0, '0, '0, 1'b1, 1'b0);
    checks += 1;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL skid_drain got %h exp 0", out_valid); end
`else
    step(1'b1, 10'h2, 32'h2, 1'b0, 1'b0);
    checks += 2;
    if (obs_rdy !== 1'b0) begin failures++; $display("FAIL noskid_stall_rdy got %h exp 0", obs_rdy); end
    if (out_data !== 32'h1) begin failures++; $display("FAIL noskid_hold got %h exp 1", out_data); end
    step(1'b1, 10'h2, 32'h2, 1'b1, 1'b0);
    checks += 1;
    if (out_data !== 32'h2 || out_valid !== 1'b1) begin failures++; $display("FAIL noskid_next got %h exp 2", out_data); end
`endif
  endtask

  task automatic test_flush();
    reset_dut();
    step(1'b1, 10'h11, 32'h11, 1'b0, 1'b0);
    if (SKID) step(1'b1, 10'h22, 32'h22, 1'b0, 1'b0);
    step(1'b1, 10'h33, 32'h33, 1'b1, 1'b1);
    checks += 4;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got %h exp 0", out_valid); end
    if (out_ctrl !== 10'h0) begin failures++; $display("FAIL flush_ctrl got %h exp 0", out_ctrl); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_rdy got %h exp 1", in_ready); end
    if (out_data !== 32'h11) begin failures++; $display("FAIL flush_data_kept got %h exp 11", out_data); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, '0, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || out_data === 32'h33) begin
        failures++; $display("FAIL flush_no_33 got valid=%h data=%h exp valid=0", out_valid, out_data);
      end
    end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 10'(k), 32'(k * 32'h0101_0101), 1'b1, 1'b0);
      checks += 2;
      if (obs_rdy !== 1'b1) begin failures++; $display("FAIL b2b_rdy[%0d] got %h exp 1", k, obs_rdy); end
      if (out_valid !== 1'b1 || out_data !== 32'(k * 32'h0101_0101)) begin
        failures++; $display("FAIL b2b_data[%0d] got %h exp %h", k, out_data, 32'(k * 32'h0101_0101));
      end
    end
    step(1'b0, '0, '0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got %h exp 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    step(1'b1, 10'h3C, 32'h1234, 1'b0, 1'b0);
    step(1'b1, 10'h3D, 32'h5678, 1'b0, 1'b0);
    #2;
    rst_n = 0;
    #1;
    checks += 5;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got %h exp 0", out_valid); end
    if (out_ctrl !== 10'h0) begin failures++; $display("FAIL midrst_ctrl got %h exp 0", out_ctrl); end
    if (out_data !== 32'h0) begin failures++; $display("FAIL midrst_data got %h exp 0", out_data); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_rdy got %h exp 1", in_ready); end
    if (bubble_cnt !== 16'h0) begin failures++; $display("FAIL midrst_bubble got %h exp 0", bubble_cnt); end
    mq.delete(); m_last = '0; m_bub = '0;
    @(negedge clk);
    rst_n = 1;
    step(1'b1, 10'h155, 32'hCAFEF00D, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hCAFEF00D) begin
      failures++; $display("FAIL midrst_first got %h exp cafef00d", out_data);
    end
  endtask

  task automatic test_random();
    logic        ordy;
    logic [9:0]  ec;
    logic [31:0] ed;
    reset_dut();
    for (int i = 0; i < 800; i++) begin
      ordy = ((i % 100) < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 3) != 0, 10'($urandom), $urandom, ordy, $urandom_range(0, 19) == 0);
      ec = (mq.size() > 0) ? mq[0].c : 10'h0;
      ed = (mq.size() > 0) ? mq[0].d : m_last;
      checks += 5;
      if (obs_rdy !== exp_rdy) begin failures++; $display("FAIL rnd_rdy[%0d] got %h exp %h", i, obs_rdy, exp_rdy); end
      if (out_valid !== (mq.size() > 0)) begin failures++; $display("FAIL rnd_valid[%0d] got %h exp %h", i, out_valid, mq.size() > 0); end
      if (out_ctrl !== ec) begin failures++; $display("FAIL rnd_ctrl[%0d] got %h exp %h", i, out_ctrl, ec); end
      if (out_data !== ed) begin failures++; $display("FAIL rnd_data[%0d] got %h exp %h", i, out_data, ed); end
      if (bubble_cnt !== m_bub) begin failures++; $display("FAIL rnd_bubble[%0d] got %0d exp %0d", i, bubble_cnt, m_bub); end
    end
  endtask

  initial begin
    rst_n = 0;
    s_in_valid = 0; s_in_ctrl = '0; s_in_data = '0; s_flush = 0; s_out_ready = 1;
    test_reset();
    test_basic();
    test_bubble();
    test_skid();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter DATA_W, default 32: width of the datapath payload (immediates, bus values, register numbers).
REQ-002 Parameter CTRL_W, default 10: width of the control payload; the all-zero value is the NOP/bubble encoding.
REQ-003 Parameter CNT_W, default 16: width of the bubble counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream stage offers a beat.
REQ-007 in_ready  output  1  stage accepts the beat this cycle.
REQ-008 in_ctrl  input  CTRL_W  control payload of the offered beat.
REQ-009 in_data  input  DATA_W  datapath payload of the offered beat.
REQ-010 flush  input  1  synchronous kill of all held beats (branch/hazard squash).
REQ-011 out_valid  output  1  stage presents a beat downstream.
REQ-012 out_ready  input  1  downstream accepts the presented beat.
REQ-013 out_ctrl  output  CTRL_W  control payload; forced to 0 whenever out_valid=0.
REQ-014 out_data  output  DATA_W  datapath payload; holds its last value when out_valid=0.
REQ-015 bubble_cnt  output  CNT_W  saturating count of cycles with out_valid=0 and out_ready=1.

Function
REQ-016 Accept = in_valid&&in_ready; dequeue = out_valid&&out_ready; beats leave in acceptance order, none duplicated or dropped.
REQ-017 Latency: a beat accepted in cycle N is presented with out_valid=1 in cycle N+1.
REQ-018 Storage: main register (drives outputs) plus skid register; FSM states EMPTY, ONE, TWO.
REQ-019 EMPTY: accept -> ONE with main<=input; otherwise stay.
REQ-020 ONE: accept without dequeue -> TWO with skid<=input; accept with dequeue -> ONE with main<=input; dequeue only -> EMPTY.
REQ-021 TWO: no accept possible; dequeue -> ONE with main<=skid.
REQ-022 in_ready is a registered output: 1 in EMPTY and ONE, 0 in TWO; no combinational path from out_ready to in_ready.
REQ-023 flush has highest priority: next state EMPTY, ctrl fields of main and skid cleared to 0, data fields unchanged, any beat offered the same cycle discarded, no dequeue counted.
REQ-024 flush while EMPTY is a no-op apart from discarding the offered beat.
REQ-025 bubble_cnt increments by 1 per qualifying cycle, holds at all-ones, and is cleared only by reset (flush does not clear it).

Reset
REQ-026 rst_n low asynchronously forces state EMPTY, main and skid registers 0, bubble_cnt 0, so out_valid=0, out_ctrl=0, out_data=0, in_ready=1.
REQ-027 Reset asserted mid-operation discards all held beats; first accept is possible in the first rising edge after rst_n rises.

Configuration
REQ-028 Macro PIPE_STAGE_SKID_EN defined: skid register and TWO state present, behaviour per REQ-018..REQ-022.
REQ-029 PIPE_STAGE_SKID_EN undefined: no skid register, states EMPTY/ONE only, in_ready = !out_valid || out_ready (combinational); all other requirements unchanged.

Structure
REQ-030 Shared package pipe_pkg holds the state enum (EMPTY, ONE, TWO), default DATA_W/CTRL_W/CNT_W constants and the ID/EX control bit positions (RegDst, ALUSrc, ALUop[2:0], MemtoReg, RegWr, MemWr, ExtOp, R_type).
REQ-031 Sub-module pipe_sat_counter (CNT_W-wide saturating up-counter, async active-low reset) implements bubble_cnt.

Verification
REQ-032 Reset then in_valid=1, in_ctrl=0x2A5, in_data=0xDEADBEEF, out_ready=1 -> next cycle out_valid=1, out_ctrl=0x2A5, out_data=0xDEADBEEF.
REQ-033 Skid build: 3 back-to-back beats 0x1,0x2,0x3 with out_ready=0 -> in_ready=0 after 2nd accept, 3rd held upstream; release out_ready -> outputs 0x1,0x2,0x3 in order.
REQ-034 State TWO holding 0x11,0x22 plus flush=1 and in_valid=1 (0x33) -> next cycle out_valid=0, out_ctrl=0, in_ready=1, 0x33 never appears.
REQ-035 Idle 5 cycles with out_ready=1 after reset -> bubble_cnt=5; with CNT_W=4, 20 idle cycles -> bubble_cnt=0xF.
REQ-036 rst_n pulsed low while in TWO -> outputs all 0 immediately, in_ready=1, bubble_cnt=0.
REQ-037 Build without PIPE_STAGE_SKID_EN, ONE with out_ready=1 and in_valid=1 -> in_ready=1 same cycle, one beat per cycle sustained, no beat lost.
